// File: rtl/fir_decim_pkg.sv
// Shared helpers for the FIR decimating output FIFO.
// - ptr_width / level_width : pointer and occupancy widths for a FIFO of a given depth.
// - sat_round               : narrows a sign-extended sample by dropping sh LSBs, with
//                             optional round-half-up plus saturation to out_w bits.
package fir_decim_pkg;

  localparam int unsigned CALC_W = 64;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned level_width(input int unsigned depth);
    return ptr_width(depth) + 1;
  endfunction

  // Result is sign-extended to CALC_W; the caller keeps the low out_w bits.
  function automatic logic signed [CALC_W-1:0] sat_round(
    input logic signed [CALC_W-1:0] x,
    input int unsigned              sh,
    input int unsigned              out_w,
    input logic                     round_en
  );
    logic signed [CALC_W-1:0] y;
    logic signed [CALC_W-1:0] max_v;
    logic signed [CALC_W-1:0] min_v;
    max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (out_w - 1));
    if (sh == 0) begin
      y = x;
    end else if (round_en) begin
      y = (x + (64'sd1 <<< (sh - 1))) >>> sh;
      // Only the positive side can exceed the range after adding half an LSB.
      if (y > max_v) begin
        y = max_v;
      end else if (y < min_v) begin
        y = min_v;
      end
    end else begin
      y = x >>> sh;
    end
    return y;
  endfunction

endpackage

// File: rtl/fir_sfifo.sv
// Synchronous show-ahead FIFO. The head entry is kept in a register so o_dout and
// o_valid are registered outputs; o_dout reads 0 while the FIFO is empty.
// Ports: i_clk, i_rst (sync, active-high), i_push/i_din, i_pop, o_dout, o_valid,
//        o_level (occupancy), o_full_c (combinational full, derived from o_level).
// A push while full is accepted only when a pop happens in the same cycle.
module fir_sfifo
  import fir_decim_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_push,
  input  logic [WIDTH-1:0]              i_din,
  input  logic                          i_pop,
  output logic [WIDTH-1:0]              o_dout,
  output logic                          o_valid,
  output logic [level_width(DEPTH)-1:0] o_level,
  output logic                          o_full_c
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned LW = level_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_nxt;
  logic [LW-1:0]    level_nxt;
  logic [WIDTH-1:0] head_nxt;
  logic             push_ok;
  logic             pop_ok;

  assign o_full_c = (o_level == LW'(DEPTH));

  // Accepted operations, next occupancy and next head entry.
  always_comb begin
    pop_ok    = i_pop && (o_level != '0);
    push_ok   = i_push && (!o_full_c || pop_ok);
    rd_nxt    = pop_ok ? rd_ptr + PW'(1) : rd_ptr;
    level_nxt = o_level;
    head_nxt  = '0;
    case ({push_ok, pop_ok})
      2'b10:   level_nxt = o_level + LW'(1);
      2'b01:   level_nxt = o_level - LW'(1);
      default: level_nxt = o_level;
    endcase
    // A write landing on the next head slot is forwarded from i_din.
    if (level_nxt != '0) begin
      head_nxt = (push_ok && (wr_ptr == rd_nxt)) ? i_din : mem[rd_nxt];
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= i_din;
    end
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_level <= '0;
      o_valid <= 1'b0;
      o_dout  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      rd_ptr  <= rd_nxt;
      o_level <= level_nxt;
      o_valid <= (level_nxt != '0);
      o_dout  <= head_nxt;
    end
  end

endmodule

// File: rtl/fir_decim_fifo.sv
// Decimates the FIR output stream (keeps 1 of every DECIM strobes), narrows each
// kept sample to OUT_WIDTH and buffers it for a valid/ready consumer.
// Ports: i_clk, i_rst (sync, active-high), i_clk_fir (sample strobe), i_data,
//        i_sync (phase restart), o_data/o_valid/i_ready (output stream),
//        o_level (FIFO occupancy), o_overflow (sticky drop flag).
// Build option: define FIR_DECIM_ROUND_EN for round-half-up with saturation;
//               otherwise the narrowing is plain arithmetic truncation.
module fir_decim_fifo
  import fir_decim_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned OUT_WIDTH  = 16,
  parameter int unsigned DECIM      = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_clk_fir,
  input  logic [DATA_WIDTH-1:0]              i_data,
  input  logic                               i_sync,
  output logic [OUT_WIDTH-1:0]               o_data,
  output logic                               o_valid,
  input  logic                               i_ready,
  output logic [level_width(FIFO_DEPTH)-1:0] o_level,
  output logic                               o_overflow
);

  localparam int unsigned SH   = DATA_WIDTH - OUT_WIDTH;
  localparam int unsigned PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
`ifdef FIR_DECIM_ROUND_EN
  localparam logic ROUND_EN = 1'b1;
`else
  localparam logic ROUND_EN = 1'b0;
`endif

  logic [PH_W-1:0]      phase;
  logic [PH_W-1:0]      phase_nxt;
  logic                 keep_c;
  logic                 pop_c;
  logic                 full_c;
  logic [OUT_WIDTH-1:0] narrow_c;

  assign pop_c    = o_valid && i_ready;
  assign narrow_c = OUT_WIDTH'(sat_round(CALC_W'(signed'(i_data)), SH, OUT_WIDTH, ROUND_EN));

  // Keep decision and next decimation phase; a sync strobe counts as phase 0.
  always_comb begin
    keep_c    = i_clk_fir && (i_sync || (phase == '0));
    phase_nxt = phase;
    if (i_sync && i_clk_fir) begin
      phase_nxt = (DECIM > 1) ? PH_W'(1) : '0;
    end else if (i_sync) begin
      phase_nxt = '0;
    end else if (i_clk_fir) begin
      phase_nxt = (phase == PH_W'(DECIM - 1)) ? '0 : phase + PH_W'(1);
    end
  end

  // Phase counter and sticky overflow.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      phase      <= '0;
      o_overflow <= 1'b0;
    end else begin
      phase <= phase_nxt;
      if (keep_c && full_c && !pop_c) begin
        o_overflow <= 1'b1;
      end
    end
  end

  fir_sfifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_push   (keep_c),
    .i_din    (narrow_c),
    .i_pop    (pop_c),
    .o_dout   (o_data),
    .o_valid  (o_valid),
    .o_level  (o_level),
    .o_full_c (full_c)
  );

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Directed bench for fir_decim_fifo (DATA_WIDTH=24, OUT_WIDTH=16, DECIM=4, FIFO_DEPTH=4).
module tb_fir_decim_fifo;

  logic        i_clk;
  logic        i_rst;
  logic        i_clk_fir;
  logic [23:0] i_data;
  logic        i_sync;
  logic [15:0] o_data;
  logic        o_valid;
  logic        i_ready;
  logic [2:0]  o_level;
  logic        o_overflow;

  int n_chk;
  int n_pass;

`ifdef FIR_DECIM_ROUND_EN
  localparam logic [15:0] EXP_R_POS = 16'h0002;
  localparam logic [15:0] EXP_R_NEG = 16'hFFFF;
`else
  localparam logic [15:0] EXP_R_POS = 16'h0001;
  localparam logic [15:0] EXP_R_NEG = 16'hFFFE;
`endif

  fir_decim_fifo #(
    .DATA_WIDTH (24),
    .OUT_WIDTH  (16),
    .DECIM      (4),
    .FIFO_DEPTH (4)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clk_fir  (i_clk_fir),
    .i_data     (i_data),
    .i_sync     (i_sync),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_level    (o_level),
    .o_overflow (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One-cycle strobe; outputs are observable right after return.
  task automatic strobe(input logic [23:0] d);
    i_clk_fir = 1'b1;
    i_data    = d;
    step();
    i_clk_fir = 1'b0;
    i_data    = '0;
  endtask

  // Three non-kept strobes with gaps, bringing the phase back to 0.
  task automatic skip3();
    for (int k = 0; k < 3; k++) begin
      strobe(24'h0);
      step();
    end
  endtask

  initial begin
    i_clk = 1'b0; i_rst = 1'b1; i_clk_fir = 1'b0; i_data = '0;
    i_sync = 1'b0; i_ready = 1'b1;
    n_chk = 0; n_pass = 0;
    step(); step();
    i_rst = 1'b0;
    chk("rst_valid", 32'(o_valid), 32'h0);
    chk("rst_level", 32'(o_level), 32'h0);
    chk("rst_ovf",   32'(o_overflow), 32'h0);
    chk("rst_data",  32'(o_data), 32'h0);

    // Decimation: only strobes 1 and 5 are kept.
    for (int k = 1; k <= 8; k++) begin
      strobe(24'(k << 8));
      if (k == 1 || k == 5) begin
        chk("dec_valid", 32'(o_valid), 32'h1);
        chk("dec_data",  32'(o_data), 32'(k));
      end else begin
        chk("dec_skip",  32'(o_valid), 32'h0);
      end
      step();
    end

    // Narrowing: rounding and saturation.
    strobe(24'h000180); chk("rnd_pos", 32'(o_data), 32'(EXP_R_POS)); step(); skip3();
    strobe(24'hFFFE80); chk("rnd_neg", 32'(o_data), 32'(EXP_R_NEG)); step(); skip3();
    strobe(24'h7FFF80); chk("sat_pos", 32'(o_data), 32'h7FFF);       step(); skip3();
    strobe(24'h800000); chk("sat_neg", 32'(o_data), 32'h8000);       step(); skip3();

    // Fill with i_ready=0: fifth keep is dropped.
    i_ready = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      strobe(24'((j + 16) << 8));
      step();
      if (j == 4) begin
        chk("full_level", 32'(o_level), 32'h4);
        chk("full_ovf0",  32'(o_overflow), 32'h0);
      end
      skip3();
    end
    chk("ovf_level", 32'(o_level), 32'h4);
    chk("ovf_flag",  32'(o_overflow), 32'h1);
    chk("ovf_head",  32'(o_data), 32'h11);
    i_ready = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      chk("drain_data",  32'(o_data), 32'(16 + j));
      chk("drain_level", 32'(o_level), 32'(5 - j));
      step();
    end
    chk("drain_empty", 32'(o_valid), 32'h0);
    chk("drain_lvl0",  32'(o_level), 32'h0);
    chk("drain_ovf",   32'(o_overflow), 32'h1);
    chk("drain_data0", 32'(o_data), 32'h0);

    // Full with simultaneous pop.
    i_rst = 1'b1; step(); i_rst = 1'b0;
    chk("rst2_ovf", 32'(o_overflow), 32'h0);
    i_ready = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      strobe(24'((j + 32) << 8));
      step();
      skip3();
    end
    chk("fp_full", 32'(o_level), 32'h4);
    i_ready = 1'b1;
    strobe(24'h002500);
    chk("fp_level", 32'(o_level), 32'h4);
    chk("fp_ovf",   32'(o_overflow), 32'h0);
    for (int j = 0; j < 4; j++) begin
      chk("fp_order", 32'(o_data), 32'(8'h22 + j));
      step();
    end
    chk("fp_empty", 32'(o_valid), 32'h0);

    // Sync: phase is 1 here; one strobe moves it to 2, then sync restarts it.
    strobe(24'h003000);
    chk("sync_skip", 32'(o_valid), 32'h0);
    step();
    i_sync = 1'b1; step(); i_sync = 1'b0;
    strobe(24'h003300);
    chk("sync_keep", 32'(o_data), 32'h33);
    step();
    i_sync = 1'b1;
    strobe(24'h003400);
    i_sync = 1'b0;
    chk("sync_strobe", 32'(o_data), 32'h34);
    step();
    strobe(24'h003500);
    chk("sync_ph1", 32'(o_valid), 32'h0);
    step();

    // Reset mid-stream with three buffered samples.
    i_ready = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      i_sync = 1'b1;
      strobe(24'((j + 64) << 8));
      i_sync = 1'b0;
      step();
    end
    chk("mid_level", 32'(o_level), 32'h3);
    i_rst = 1'b1; step(); i_rst = 1'b0;
    chk("mid_valid", 32'(o_valid), 32'h0);
    chk("mid_lvl0",  32'(o_level), 32'h0);
    chk("mid_ovf",   32'(o_overflow), 32'h0);
    i_ready = 1'b1;
    strobe(24'h004400);
    chk("post_rst_valid", 32'(o_valid), 32'h1);
    chk("post_rst_data",  32'(o_data), 32'h44);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
